// File: rtl/adc128s022_responder_if.sv
// ADC128S022 SPI bus plus host channel-write port shared between the
// controller/host side (master) and the emulated ADC (slave).
interface adc128s022_responder_if;
  logic        adc_cs_n;
  logic        adc_sck;
  logic        din;
  logic        dout;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [11:0] wr_data;

  modport master (
    output adc_cs_n, adc_sck, din, wr_en, wr_ch, wr_data,
    input  dout
  );

  modport slave (
    input  adc_cs_n, adc_sck, din, wr_en, wr_ch, wr_data,
    output dout
  );
endinterface

// File: rtl/adc128s022_responder.sv
// Emulated ADC128S022: oversamples the controller's SPI pins in clk_50 and
// returns host-loaded 12-bit channel values in the real chip's frame format.
module adc128s022_responder #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [11:0] CH_RESET    = 12'd0
) (
  input  logic                  clk_50,
  input  logic                  rst,
  adc128s022_responder_if.slave bus,
  output logic                  frame_done,
  output logic [2:0]            last_ch,
  output logic [3:0]            bit_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_p0, sck_sync_p0, din_sync_p0;
  logic                   cs_d_p1, sck_d_p1;
  logic                   cs_s, sck_s, din_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;

  logic [11:0] ch_reg [8];

  state_t      state, state_n;
  logic [15:0] shift, shift_n;
  logic        dout_r, dout_n;
  logic [3:0]  cnt_n;
  logic [2:0]  cur_ch, cur_n, nxt_ch, nxt_n, last_n;
  logic        fd_n;
  logic        reload, reload_n;

  // Stage p0: pin synchronizers. CS resets low so a pin already low at
  // reset release cannot fake a falling edge; a real high-then-low is needed.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      cs_sync_p0  <= '0;
      sck_sync_p0 <= '0;
    end else begin
      cs_sync_p0  <= {cs_sync_p0[SYNC_STAGES-2:0], bus.adc_cs_n};
      sck_sync_p0 <= {sck_sync_p0[SYNC_STAGES-2:0], bus.adc_sck};
    end
  end

  always_ff @(posedge clk_50) begin
    din_sync_p0 <= {din_sync_p0[SYNC_STAGES-2:0], bus.din};
  end

  assign cs_s  = cs_sync_p0[SYNC_STAGES-1];
  assign sck_s = sck_sync_p0[SYNC_STAGES-1];
  assign din_s = din_sync_p0[SYNC_STAGES-1];

  // Stage p1: delayed copies for one-cycle edge pulses
  always_ff @(posedge clk_50) begin
    if (rst) begin
      cs_d_p1  <= 1'b0;
      sck_d_p1 <= 1'b0;
    end else begin
      cs_d_p1  <= cs_s;
      sck_d_p1 <= sck_s;
    end
  end

  assign sck_rise = sck_s & ~sck_d_p1;
  assign sck_fall = ~sck_s & sck_d_p1;
  assign cs_fall  = ~cs_s & cs_d_p1;
  assign cs_rise  = cs_s & ~cs_d_p1;

  always_ff @(posedge clk_50) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) ch_reg[i] <= CH_RESET;
    end else if (bus.wr_en) begin
      ch_reg[bus.wr_ch] <= bus.wr_data;
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    dout_n   = dout_r;
    cnt_n    = bit_cnt;
    cur_n    = cur_ch;
    nxt_n    = nxt_ch;
    last_n   = last_ch;
    fd_n     = 1'b0;
    reload_n = reload;
    case (state)
      IDLE: begin
        dout_n   = 1'b0;
        cnt_n    = 4'd0;
        reload_n = 1'b0;
        if (cs_fall) begin
          shift_n = {4'b0, ch_reg[cur_ch]};
          dout_n  = shift_n[15];
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        // CS release outranks a coincident SCK edge and aborts the frame
        if (cs_rise) begin
          state_n  = IDLE;
          dout_n   = 1'b0;
          cnt_n    = 4'd0;
          reload_n = 1'b0;
        end else begin
          if (sck_rise) begin
            cnt_n = 4'(bit_cnt + 4'd1);
            if (bit_cnt inside {4'd2, 4'd3, 4'd4}) nxt_n = {nxt_ch[1:0], din_s};
            if (bit_cnt == 4'd15) begin
              fd_n     = 1'b1;
              last_n   = cur_ch;
              cur_n    = nxt_ch;
              reload_n = 1'b1;
            end
          end
          if (sck_fall) begin
            if (reload) begin
              shift_n  = {4'b0, ch_reg[cur_ch]};
              reload_n = 1'b0;
            end else begin
              shift_n = {shift[14:0], 1'b0};
            end
            dout_n = shift_n[15];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p2: frame state and registered dout
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state      <= IDLE;
      dout_r     <= 1'b0;
      bit_cnt    <= 4'd0;
      cur_ch     <= 3'd0;
      nxt_ch     <= 3'd0;
      last_ch    <= 3'd0;
      frame_done <= 1'b0;
      reload     <= 1'b0;
    end else begin
      state      <= state_n;
      dout_r     <= dout_n;
      bit_cnt    <= cnt_n;
      cur_ch     <= cur_n;
      nxt_ch     <= nxt_n;
      last_ch    <= last_n;
      frame_done <= fd_n;
      reload     <= reload_n;
    end
  end

  always_ff @(posedge clk_50) begin
    shift <= shift_n;
  end

  assign bus.dout = dout_r;

endmodule

// File: tb/tb_adc128s022_responder.sv
// Bench for adc128s022_responder: drives SPI frames like the ADC controller and
// checks returned words against a frame-level model of the channel bank.
module tb_adc128s022_responder;
  localparam int HALF = 10;
  localparam int SYNC = 2;

  logic clk_50 = 1'b0;
  logic rst;
  always #10 clk_50 = ~clk_50;

  adc128s022_responder_if bus();
  logic       frame_done;
  logic [2:0] last_ch;
  logic [3:0] bit_cnt;

  adc128s022_responder #(.SYNC_STAGES(SYNC), .CH_RESET(12'h000)) dut (
    .clk_50(clk_50), .rst(rst), .bus(bus),
    .frame_done(frame_done), .last_ch(last_ch), .bit_cnt(bit_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int fd_count = 0;
  int fd_wide = 0;
  int fd_cyc[$];
  logic fd_prev = 1'b0;

  always @(negedge clk_50) begin
    cyc++;
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cyc.push_back(cyc);
      if (fd_prev === 1'b1) fd_wide++;
    end
    fd_prev = frame_done;
  end

  // Frame-level model: bank contents, selected channel, last channel
  logic [11:0] m_reg [8];
  logic [2:0]  m_cur, m_last;

  bit          lat_chk = 1'b0;
  logic        lat_db11;
  int          wr_k = 0;
  logic [2:0]  wr_c;
  logic [11:0] wr_d;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  task automatic host_write(input logic [2:0] c, input logic [11:0] d);
    bus.wr_en = 1'b1; bus.wr_ch = c; bus.wr_data = d;
    wait_cyc(1);
    bus.wr_en = 1'b0;
    m_reg[c] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 12'h000;
    m_cur = 3'd0; m_last = 3'd0;
  endtask

  task automatic model_advance(input logic [2:0] a);
    m_last = m_cur;
    m_cur  = a;
  endtask

  task automatic sck_bits(input logic [2:0] addr, input int nsck, input bit tail,
                          output logic [15:0] word);
    word = '0;
    for (int k = 1; k <= nsck; k++) begin
      case (k)
        3: bus.din = addr[2];
        4: bus.din = addr[1];
        5: bus.din = addr[0];
        default: bus.din = 1'($urandom_range(0, 1));
      endcase
      if (lat_chk && k == 5) begin
        wait_cyc(SYNC);
        n_tests++;
        if (bus.dout !== 1'b0) begin
          n_fail++; $display("FAIL dout_early: got %b expected %b", bus.dout, 1'b0);
        end
        wait_cyc(1);
        n_tests++;
        if (bus.dout !== lat_db11) begin
          n_fail++; $display("FAIL dout_latency: got %b expected %b", bus.dout, lat_db11);
        end
        wait_cyc(HALF - SYNC - 1);
      end else if (k == wr_k) begin
        host_write(wr_c, wr_d);
        wait_cyc(HALF - 1);
      end else begin
        wait_cyc(HALF);
      end
      word[16-k] = bus.dout;
      bus.adc_sck = 1'b1;
      if (lat_chk && k == 16) begin
        wait_cyc(SYNC);
        n_tests++;
        if (frame_done !== 1'b0) begin
          n_fail++; $display("FAIL fd_early: got %b expected %b", frame_done, 1'b0);
        end
        wait_cyc(1);
        n_tests++;
        if (frame_done !== 1'b1) begin
          n_fail++; $display("FAIL fd_latency: got %b expected %b", frame_done, 1'b1);
        end
        wait_cyc(1);
        n_tests++;
        if (frame_done !== 1'b0) begin
          n_fail++; $display("FAIL fd_width: got %b expected %b", frame_done, 1'b0);
        end
        wait_cyc(HALF - SYNC - 2);
      end else begin
        wait_cyc(HALF);
      end
      bus.adc_sck = 1'b0;
    end
    if (tail) wait_cyc(HALF);
  endtask

  task automatic run_frame(input logic [2:0] addr, output logic [15:0] word);
    bus.adc_cs_n = 1'b0;
    sck_bits(addr, 16, 1'b1, word);
    bus.adc_cs_n = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic test_reset();
    bus.adc_cs_n = 1'b1; bus.adc_sck = 1'b0; bus.din = 1'b0;
    bus.wr_en = 1'b0; bus.wr_ch = 3'd0; bus.wr_data = 12'h000;
    rst = 1'b1;
    wait_cyc(3);
    n_tests++;
    if (bus.dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b expected 0", bus.dout); end
    n_tests++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b expected 0", frame_done); end
    n_tests++;
    if (last_ch !== 3'd0) begin n_fail++; $display("FAIL reset_last_ch: got %0d expected 0", last_ch); end
    n_tests++;
    if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d expected 0", bit_cnt); end
    rst = 1'b0;
    model_reset();
    wait_cyc(HALF);
  endtask

  task automatic test_basic();
    logic [15:0] w, exp;
    int fd0;
    host_write(3'd0, 12'hABC);
    fd0 = fd_count;
    exp = {4'h0, m_reg[m_cur]};
    lat_chk = 1'b1; lat_db11 = exp[11];
    run_frame(3'b101, w);
    lat_chk = 1'b0;
    model_advance(3'b101);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL basic0_word: got %h expected %h", w, exp); end
    n_tests++;
    if (fd_count - fd0 !== 1) begin n_fail++; $display("FAIL basic0_fd: got %0d expected 1", fd_count - fd0); end
    n_tests++;
    if (last_ch !== m_last) begin n_fail++; $display("FAIL basic0_last: got %0d expected %0d", last_ch, m_last); end

    host_write(3'd5, 12'h5A5);
    exp = {4'h0, m_reg[m_cur]};
    run_frame(3'b000, w);
    model_advance(3'b000);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL basic1_word: got %h expected %h", w, exp); end
    n_tests++;
    if (last_ch !== m_last) begin n_fail++; $display("FAIL basic1_last: got %0d expected %0d", last_ch, m_last); end
  endtask

  task automatic test_continuous();
    logic [15:0] w, exp;
    logic [2:0]  addrs [3];
    int fd0;
    addrs[0] = 3'd1; addrs[1] = 3'd2; addrs[2] = 3'd7;
    for (int n = 0; n < 8; n++) host_write(3'(n), 12'(n * 256));
    fd_cyc.delete();
    fd0 = fd_count;
    bus.adc_cs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = {4'h0, m_reg[m_cur]};
      sck_bits(addrs[i], 16, 1'b0, w);
      model_advance(addrs[i]);
      n_tests++;
      if (w !== exp) begin n_fail++; $display("FAIL cont_word%0d: got %h expected %h", i, w, exp); end
      if (i == 0) begin
        n_tests++;
        if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL cont_wrap: got %0d expected 0", bit_cnt); end
      end
    end
    wait_cyc(HALF);
    bus.adc_cs_n = 1'b1;
    wait_cyc(HALF);
    n_tests++;
    if (fd_count - fd0 !== 3) begin n_fail++; $display("FAIL cont_fd_count: got %0d expected 3", fd_count - fd0); end
    if (fd_cyc.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        n_tests++;
        if (fd_cyc[i] - fd_cyc[i-1] !== 32 * HALF) begin
          n_fail++; $display("FAIL cont_fd_spacing: got %0d expected %0d", fd_cyc[i] - fd_cyc[i-1], 32 * HALF);
        end
      end
    end
    n_tests++;
    if (last_ch !== m_last) begin n_fail++; $display("FAIL cont_last: got %0d expected %0d", last_ch, m_last); end
  endtask

  task automatic test_abort();
    logic [15:0] w, exp;
    logic [2:0]  a;
    int fd0;
    fd0 = fd_count;
    bus.adc_cs_n = 1'b0;
    sck_bits(3'd6, 9, 1'b1, w);
    n_tests++;
    if (bit_cnt !== 4'd9) begin n_fail++; $display("FAIL abort_cnt: got %0d expected 9", bit_cnt); end
    bus.adc_cs_n = 1'b1;
    wait_cyc(HALF);
    n_tests++;
    if (fd_count !== fd0) begin n_fail++; $display("FAIL abort_fd: got %0d expected %0d", fd_count, fd0); end
    n_tests++;
    if (bus.dout !== 1'b0) begin n_fail++; $display("FAIL abort_dout: got %b expected 0", bus.dout); end
    n_tests++;
    if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL abort_cnt_clr: got %0d expected 0", bit_cnt); end
    a = 3'($urandom_range(0, 7));
    exp = {4'h0, m_reg[m_cur]};
    run_frame(a, w);
    model_advance(a);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL abort_next_word: got %h expected %h", w, exp); end
  endtask

  task automatic test_write_during_frame();
    logic [15:0] w, exp;
    run_frame(3'd0, w);
    model_advance(3'd0);
    host_write(3'd0, 12'hFFF);
    exp = {4'h0, m_reg[m_cur]};
    wr_k = 8; wr_c = 3'd0; wr_d = 12'h000;
    run_frame(3'd0, w);
    wr_k = 0;
    model_advance(3'd0);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL wr_snapshot: got %h expected %h", w, exp); end
    exp = {4'h0, m_reg[m_cur]};
    run_frame(3'd0, w);
    model_advance(3'd0);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL wr_later: got %h expected %h", w, exp); end
  endtask

  task automatic test_load_collision();
    logic [15:0] w, exp;
    host_write(m_cur, 12'h123);
    exp = {4'h0, m_reg[m_cur]};
    bus.adc_cs_n = 1'b0;
    wait_cyc(SYNC);
    host_write(m_cur, 12'h456);
    sck_bits(3'd4, 16, 1'b1, w);
    bus.adc_cs_n = 1'b1;
    wait_cyc(HALF);
    model_advance(3'd4);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL collide_old: got %h expected %h", w, exp); end
    host_write(3'd4, 12'h9C3);
    exp = {4'h0, m_reg[m_cur]};
    run_frame(3'd4, w);
    model_advance(3'd4);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL collide_next: got %h expected %h", w, exp); end
  endtask

  task automatic test_random();
    logic [15:0] w, exp;
    logic [2:0]  a;
    for (int i = 0; i < 6; i++) begin
      host_write(3'($urandom_range(0, 7)), 12'($urandom));
      host_write(m_cur, 12'($urandom));
      a = 3'($urandom_range(0, 7));
      exp = {4'h0, m_reg[m_cur]};
      run_frame(a, w);
      model_advance(a);
      n_tests++;
      if (w !== exp) begin n_fail++; $display("FAIL rand_word%0d: got %h expected %h", i, w, exp); end
      n_tests++;
      if (last_ch !== m_last) begin n_fail++; $display("FAIL rand_last%0d: got %0d expected %0d", i, last_ch, m_last); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] w, exp;
    int fd0;
    host_write(m_cur, 12'hFFF);
    bus.adc_cs_n = 1'b0;
    sck_bits(3'd3, 6, 1'b0, w);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    model_reset();
    n_tests++;
    if (bus.dout !== 1'b0) begin n_fail++; $display("FAIL rstmid_dout: got %b expected 0", bus.dout); end
    n_tests++;
    if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d expected 0", bit_cnt); end
    n_tests++;
    if (last_ch !== 3'd0) begin n_fail++; $display("FAIL rstmid_last: got %0d expected 0", last_ch); end
    fd0 = fd_count;
    sck_bits(3'd3, 4, 1'b1, w);
    n_tests++;
    if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_hold_cnt: got %0d expected 0", bit_cnt); end
    n_tests++;
    if (fd_count !== fd0) begin n_fail++; $display("FAIL rstmid_hold_fd: got %0d expected %0d", fd_count, fd0); end
    bus.adc_cs_n = 1'b1;
    wait_cyc(HALF);
    exp = {4'h0, m_reg[m_cur]};
    run_frame(3'd2, w);
    model_advance(3'd2);
    n_tests++;
    if (w !== exp) begin n_fail++; $display("FAIL rstmid_word: got %h expected %h", w, exp); end
    n_tests++;
    if (last_ch !== m_last) begin n_fail++; $display("FAIL rstmid_next_last: got %0d expected %0d", last_ch, m_last); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_abort();
    test_write_during_frame();
    test_load_collision();
    test_random();
    test_reset_mid_frame();
    n_tests++;
    if (fd_wide !== 0) begin n_fail++; $display("FAIL fd_pulse_width: got %0d wide pulses expected 0", fd_wide); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/adc128s022_responder.md
# adc128s022_responder

Synthesizable SPI responder that emulates the ADC128S022 8-channel 12-bit ADC. It runs in the clk_50 domain and oversamples the ADC bus driven by the existing ADC controller (adc_cs_n, adc_sck, din), then drives dout with the frame a real ADC128S022 would return. Each channel's 12-bit result comes from a host-loaded register bank. The block is used for sensor-free bring-up and loopback verification of the line-sensor path.

## Interface
- SYNC_STAGES, default 2: synchronizer depth on adc_cs_n, adc_sck and din. Legal range 2–3.
- CH_RESET, default 12'd0: reset value of every channel register.

Ports:
- clk_50  input  1  system clock, 50 MHz. All state updates on the rising edge.
- rst  input  1  reset. Synchronous and active-high.
- adc_cs_n  input  1  chip select from the controller, active low.
- adc_sck  input  1  serial clock from the controller, nominally 2.5 MHz (period ≥ 8 clk_50 cycles).
- din  input  1  serial channel address from the controller.
- dout  output  1  serial conversion data to the controller.
- wr_en  input  1  host write strobe for one channel register.
- wr_ch  input  3  channel index for the host write.
- wr_data  input  12  value for the host write.
- frame_done  output  1  one-cycle pulse when a full 16-bit frame completes.
- last_ch  output  3  channel that was shifted out in the most recent completed frame.
- bit_cnt  output  4  current SCK count within the frame (debug).

## Operation
- Synchronizers: adc_cs_n, adc_sck and din each pass through SYNC_STAGES flops.
- Edge detection: a registered copy of the synchronized signal detects sck_rise, sck_fall and cs_fall. Each is a one-cycle pulse.
- Channel bank: 8×12-bit registers. wr_en writes wr_data to reg[wr_ch] in the same cycle and is accepted at any time.
- State machine IDLE → ACTIVE:
  - IDLE (adc_cs_n high): dout=0, bit_cnt=0.
  - On cs_fall: load shift[15:0] = {4'b0, reg[cur_ch]}, set dout=shift[15]=0, enter ACTIVE.
  - ACTIVE, on sck_rise number k (k=1..16): sample din. Rising edges 3, 4 and 5 capture ADD2, ADD1 and ADD0 into nxt_ch. bit_cnt increments and wraps 15→0.
  - ACTIVE, on sck_fall following rise k (k=1..15): shift left by one and drive dout=shift[15]. dout therefore carries DB11 after falling edge 4 and DB0 after falling edge 15.
  - On the 16th sck_rise: pulse frame_done, last_ch←cur_ch, cur_ch←nxt_ch. If CS is still low, reload shift with {4'b0, reg[new cur_ch]} on the next sck_fall (continuous conversion) instead of shifting.
  - adc_cs_n rising in ACTIVE: return to IDLE; dout=0; bit_cnt=0.
- Aborted frame (CS rises before the 16th rise): no frame_done; cur_ch unchanged; nxt_ch discarded.
- Address semantics: the address received in frame N selects the data returned in frame N+1. The first frame after reset returns channel 0.
- Snapshot rule: the channel value is captured at frame load. A host write to that channel during the frame affects only later frames.
- Simultaneous events:
  - wr_en on the same cycle as a frame load to the same channel: the load takes the old value.
  - sck_rise and cs rise in the same cycle: the CS rise wins and the frame is aborted.

## Timing
- Reset values: dout=0, frame_done=0, last_ch=0, bit_cnt=0, cur_ch=0, nxt_ch=0, all channel regs=CH_RESET, state IDLE.
- Reset asserted mid-frame forces all of the above on the next clock and holds IDLE until adc_cs_n is seen high then low.
- Input-to-action latency: SYNC_STAGES+1 clk_50 cycles from a pin edge to the internal action. dout is registered.
- dout changes exactly SYNC_STAGES+1 cycles after the adc_sck falling pin edge. This is 60 ns at defaults, inside the 200 ns low phase at 2.5 MHz.
- frame_done asserts SYNC_STAGES+1 cycles after the 16th adc_sck rising edge, for exactly one cycle.
- SCK high or low phases shorter than SYNC_STAGES+1 clk_50 cycles are unsupported; behaviour is undefined.

## Test plan
- Reset, load reg[0]=12'hABC, drive one frame with din address 3'b101 → dout bits 15..0 = 0000_1010_1011_1100; frame_done once; last_ch=0.
- Load reg[5]=12'h5A5, then a second frame with address 0 → frame returns 0000_0101_1010_0101; last_ch=5.
- Continuous mode: CS held low for 48 SCKs with addresses 1, 2, 7 and reg[n]=12'h100·n → frames return ch0, ch1, ch2 data; three frame_done pulses 16 SCKs apart.
- Abort: CS rises after 9 SCKs of a frame with address 6 → no frame_done; next full frame returns the previous cur_ch data, not ch6.
- Write during frame: reg[0]=12'hFFF is loaded, then wr_en writes 12'h000 to ch0 at SCK 8 → that frame still returns 12'hFFF; the next ch0 frame returns 12'h000.
- Reset mid-frame at SCK 6 → dout=0, bit_cnt=0, the following frame returns channel 0 with CH_RESET data.
